// File: rtl/dual_issue_scheduler.sv
// Two-wide issue controller: dual-issues independent queue-head pairs and
// serializes RAW/WAW-dependent pairs over two enabled ticks.
module dual_issue_scheduler #(
  parameter int CNT_W  = 16,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              en,
  input  logic              valid0,
  input  logic              valid1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [REG_AW-1:0] rd0,
  input  logic [REG_AW-1:0] rs1_0,
  input  logic [REG_AW-1:0] rs2_0,
  input  logic [REG_AW-1:0] rd1,
  input  logic [REG_AW-1:0] rs1_1,
  input  logic [REG_AW-1:0] rs2_1,
  input  logic              use_rs2_1,
  output logic              issue0,
  output logic              issue1,
  output logic              reg_write0,
  output logic              reg_write1,
  output logic              freeze1,
  output logic              freeze2,
  output logic              dependency_on_ins2,
  output logic [CNT_W-1:0]  dual_cnt,
  output logic [CNT_W-1:0]  serial_cnt
);

  typedef enum logic {ST_ISSUE, ST_SERIAL} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] dual_q, dual_d;
  logic [CNT_W-1:0] serial_q, serial_d;
  logic             hazard;

  // Slot 0 source fields never create a hazard against slot 1.
  logic unused_slot0_srcs;
  assign unused_slot0_srcs = ^{rs1_0, rs2_0};

  assign hazard = valid0 & valid1 & wr0 & (rd0 != '0) &
                  ((rd0 == rs1_1) | (use_rs2_1 & (rd0 == rs2_1)) | (wr1 & (rd0 == rd1)));

  always_comb begin
    state_d  = state_q;
    dual_d   = dual_q;
    serial_d = serial_q;
    issue0   = 1'b0;
    issue1   = 1'b0;
    freeze1  = 1'b0;
    freeze2  = 1'b0;
    if (n_rst && en) begin
      case (state_q)
        ST_ISSUE: begin
          if (valid0 && valid1) begin
            issue0 = 1'b1;
            if (hazard) begin
              freeze2  = 1'b1;
              state_d  = ST_SERIAL;
              serial_d = (serial_q == '1) ? serial_q : serial_q + CNT_W'(1);
            end else begin
              issue1 = 1'b1;
              dual_d = (dual_q == '1) ? dual_q : dual_q + CNT_W'(1);
            end
          end else begin
            issue0 = valid0;
            issue1 = valid1;
          end
        end
        ST_SERIAL: begin
          // Slot 0 already retired last tick; only the held slot 1 goes now.
          freeze1 = 1'b1;
          issue1  = valid1;
          state_d = ST_ISSUE;
        end
        default: state_d = ST_ISSUE;
      endcase
    end
  end

  assign reg_write0         = issue0 & wr0 & (rd0 != '0);
  assign reg_write1         = issue1 & wr1 & (rd1 != '0);
  assign dependency_on_ins2 = n_rst & (state_q == ST_SERIAL);
  assign dual_cnt           = dual_q;
  assign serial_cnt         = serial_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q  <= ST_ISSUE;
      dual_q   <= '0;
      serial_q <= '0;
    end else begin
      state_q  <= state_d;
      dual_q   <= dual_d;
      serial_q <= serial_d;
    end
  end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Self-checking bench: directed vector table, en-hold/reset sequences, and a
// randomized run against a pair-level reference model (16-bit and 2-bit counters).
module tb_dual_issue_scheduler;

  logic       clk = 1'b0;
  logic       n_rst, en, valid0, valid1, wr0, wr1, use_rs2_1;
  logic [4:0] rd0, rs1_0, rs2_0, rd1, rs1_1, rs2_1;
  logic       issue0, issue1, reg_write0, reg_write1, freeze1, freeze2, dep;
  logic [15:0] dual_cnt, serial_cnt;
  logic       s_issue0, s_issue1, s_rw0, s_rw1, s_f1, s_f2, s_dep;
  logic [1:0] s_dual, s_serial;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dual_issue_scheduler #(.CNT_W(16), .REG_AW(5)) dut (
    .clk(clk), .n_rst(n_rst), .en(en), .valid0(valid0), .valid1(valid1),
    .wr0(wr0), .wr1(wr1), .rd0(rd0), .rs1_0(rs1_0), .rs2_0(rs2_0),
    .rd1(rd1), .rs1_1(rs1_1), .rs2_1(rs2_1), .use_rs2_1(use_rs2_1),
    .issue0(issue0), .issue1(issue1), .reg_write0(reg_write0), .reg_write1(reg_write1),
    .freeze1(freeze1), .freeze2(freeze2), .dependency_on_ins2(dep),
    .dual_cnt(dual_cnt), .serial_cnt(serial_cnt)
  );

  // Narrow-counter copy on the same inputs exercises saturation quickly.
  dual_issue_scheduler #(.CNT_W(2), .REG_AW(5)) dut_small (
    .clk(clk), .n_rst(n_rst), .en(en), .valid0(valid0), .valid1(valid1),
    .wr0(wr0), .wr1(wr1), .rd0(rd0), .rs1_0(rs1_0), .rs2_0(rs2_0),
    .rd1(rd1), .rs1_1(rs1_1), .rs2_1(rs2_1), .use_rs2_1(use_rs2_1),
    .issue0(s_issue0), .issue1(s_issue1), .reg_write0(s_rw0), .reg_write1(s_rw1),
    .freeze1(s_f1), .freeze2(s_f2), .dependency_on_ins2(s_dep),
    .dual_cnt(s_dual), .serial_cnt(s_serial)
  );

  typedef struct {
    logic       rst_n, en, v0, v1, w0, w1, u2;
    logic [4:0] rd0, rs1_1, rs2_1, rd1;
    logic [6:0] exp_comb;   // {issue0, issue1, rw0, rw1, freeze1, freeze2, dep}
    logic       exp_dep_after;
    int         exp_dual, exp_ser;
  } vec_t;

  vec_t vecs[19];

  function automatic logic [6:0] comb_now();
    return {issue0, issue1, reg_write0, reg_write1, freeze1, freeze2, dep};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic v0, input logic v1,
                       input logic w0, input logic w1, input logic [4:0] d0,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d1,
                       input logic u2);
    n_rst = r; en = e; valid0 = v0; valid1 = v1; wr0 = w0; wr1 = w1;
    rd0 = d0; rs1_1 = a1; rs2_1 = a2; rd1 = d1; use_rs2_1 = u2;
    rs1_0 = 5'($urandom_range(0, 31)); rs2_0 = 5'($urandom_range(0, 31));
  endtask

  function automatic vec_t mk(input logic r, input logic e, input logic v0, input logic v1,
                              input logic w0, input logic w1, input logic [4:0] d0,
                              input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d1,
                              input logic u2, input logic [6:0] ec, input logic da,
                              input int ed, input int es);
    vec_t v;
    v.rst_n = r; v.en = e; v.v0 = v0; v.v1 = v1; v.w0 = w0; v.w1 = w1;
    v.rd0 = d0; v.rs1_1 = a1; v.rs2_1 = a2; v.rd1 = d1; v.u2 = u2;
    v.exp_comb = ec; v.exp_dep_after = da; v.exp_dual = ed; v.exp_ser = es;
    return v;
  endfunction

  // Reference model state: a dependent pair is "pending" between its two ticks.
  bit pending;
  int m_dual, m_ser, m_dual_s, m_ser_s;

  initial begin
    bit e_i0, e_i1, e_f1, e_f2, hz;
    logic [6:0] ec;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);

    //            rst en v0 v1 w0 w1 rd0 rs1 rs2 rd1 u2  comb        dep  dual ser
    vecs[0]  = mk(0, 1, 1, 1, 1, 1, 3, 3, 5, 6, 1, 7'b0000000, 0, 0, 0);
    vecs[1]  = mk(1, 1, 1, 1, 1, 1, 3, 4, 5, 6, 1, 7'b1111000, 0, 1, 0);
    vecs[2]  = mk(1, 1, 1, 1, 1, 1, 3, 3, 5, 6, 1, 7'b1010010, 1, 1, 1);
    vecs[3]  = mk(1, 1, 1, 1, 1, 1, 3, 3, 5, 6, 1, 7'b0101101, 0, 1, 1);
    vecs[4]  = mk(1, 1, 1, 1, 1, 1, 0, 0, 5, 6, 1, 7'b1101000, 0, 2, 1);
    vecs[5]  = mk(1, 1, 1, 1, 0, 1, 3, 3, 5, 6, 1, 7'b1101000, 0, 3, 1);
    vecs[6]  = mk(1, 1, 1, 1, 1, 1, 3, 4, 3, 6, 0, 7'b1111000, 0, 4, 1);
    vecs[7]  = mk(1, 1, 1, 1, 1, 1, 7, 1, 2, 7, 1, 7'b1010010, 1, 4, 2);
    vecs[8]  = mk(1, 1, 1, 1, 1, 1, 7, 1, 2, 7, 1, 7'b0101101, 0, 4, 2);
    vecs[9]  = mk(1, 0, 1, 1, 1, 1, 3, 3, 5, 6, 1, 7'b0000000, 0, 4, 2);
    vecs[10] = mk(1, 1, 1, 1, 1, 1, 3, 3, 5, 6, 1, 7'b1010010, 1, 4, 3);
    vecs[11] = mk(0, 1, 1, 1, 1, 1, 3, 3, 5, 6, 1, 7'b0000000, 0, 0, 0);
    vecs[12] = mk(1, 1, 1, 1, 1, 1, 3, 4, 5, 6, 1, 7'b1111000, 0, 1, 0);
    vecs[13] = mk(1, 1, 1, 0, 1, 1, 3, 3, 5, 6, 1, 7'b1010000, 0, 1, 0);
    vecs[14] = mk(1, 1, 0, 1, 1, 1, 3, 3, 5, 6, 1, 7'b0101000, 0, 1, 0);
    vecs[15] = mk(1, 1, 0, 0, 1, 1, 3, 3, 5, 6, 1, 7'b0000000, 0, 1, 0);
    vecs[16] = mk(1, 1, 1, 1, 1, 1, 3, 3, 5, 6, 1, 7'b1010010, 1, 1, 1);
    vecs[17] = mk(1, 0, 1, 1, 1, 1, 3, 3, 5, 6, 1, 7'b0000001, 1, 1, 1);
    vecs[18] = mk(1, 1, 1, 1, 1, 1, 3, 3, 5, 6, 1, 7'b0101101, 0, 1, 1);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i].rst_n, vecs[i].en, vecs[i].v0, vecs[i].v1, vecs[i].w0, vecs[i].w1,
            vecs[i].rd0, vecs[i].rs1_1, vecs[i].rs2_1, vecs[i].rd1, vecs[i].u2);
      #1;
      chk($sformatf("vec%0d_comb", i), int'(comb_now()), int'(vecs[i].exp_comb));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_dep", i), int'(dep), int'(vecs[i].exp_dep_after));
      chk($sformatf("vec%0d_dual", i), int'(dual_cnt), vecs[i].exp_dual);
      chk($sformatf("vec%0d_ser", i), int'(serial_cnt), vecs[i].exp_ser);
      $display("vec %0d: comb=%b dep=%0d dual=%0d ser=%0d", i, comb_now(), dep, dual_cnt, serial_cnt);
    end

    // en held low for 10 cycles with hazard inputs: nothing moves.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 5'd3, 5'd3, 5'd3, 1'b1);
      #1;
      chk($sformatf("hold%0d_comb", i), int'(comb_now()), 0);
      @(posedge clk); #1;
      chk($sformatf("hold%0d_cnt", i), int'({dual_cnt, serial_cnt}), int'({16'd1, 16'd1}));
      $display("hold %0d: comb=%b dual=%0d ser=%0d", i, comb_now(), dual_cnt, serial_cnt);
    end
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 5'd3, 5'd3, 5'd3, 1'b1);
    @(posedge clk); #1;
    chk("after_hold_ser", int'(serial_cnt), 2);
    chk("after_hold_dep", int'(dep), 1);

    // Randomized run; first cycle resets so the model starts from a known state.
    pending = 0; m_dual = 0; m_ser = 0; m_dual_s = 0; m_ser_s = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      n_rst = (c == 0) ? 1'b0 : ($urandom_range(0, 99) >= 2);
      en    = ($urandom_range(0, 3) != 0);
      valid0 = 1'($urandom); wr0 = ($urandom_range(0, 3) != 0);
      rd0 = 5'($urandom_range(0, 3));
      rs1_0 = 5'($urandom); rs2_0 = 5'($urandom);
      if (!pending) begin
        valid1 = ($urandom_range(0, 3) != 0); wr1 = 1'($urandom);
        rd1 = 5'($urandom_range(0, 3)); rs1_1 = 5'($urandom_range(0, 3));
        rs2_1 = 5'($urandom_range(0, 3)); use_rs2_1 = 1'($urandom);
      end
      e_i0 = 0; e_i1 = 0; e_f1 = 0; e_f2 = 0;
      hz = valid0 && valid1 && wr0 && rd0 != 0 &&
           (rd0 == rs1_1 || (use_rs2_1 && rd0 == rs2_1) || (wr1 && rd0 == rd1));
      #1;
      ec = 7'd0;
      if (n_rst && en) begin
        if (pending) begin
          e_f1 = 1; e_i1 = valid1;
        end else if (valid0 && valid1) begin
          e_i0 = 1; e_i1 = !hz; e_f2 = hz;
        end else begin
          e_i0 = valid0; e_i1 = valid1;
        end
      end
      ec = {e_i0, e_i1, e_i0 && wr0 && rd0 != 0, e_i1 && wr1 && rd1 != 0, e_f1, e_f2,
            n_rst && pending};
      chk($sformatf("rnd%0d_comb", c), int'(comb_now()), int'(ec));
      chk($sformatf("rnd%0d_small_comb", c),
          int'({s_issue0, s_issue1, s_rw0, s_rw1, s_f1, s_f2, s_dep}), int'(ec));
      if (!n_rst) begin
        pending = 0; m_dual = 0; m_ser = 0; m_dual_s = 0; m_ser_s = 0;
      end else if (en) begin
        if (pending) pending = 0;
        else if (valid0 && valid1) begin
          if (hz) begin
            pending = 1;
            if (m_ser < 65535) m_ser++;
            if (m_ser_s < 3) m_ser_s++;
          end else begin
            if (m_dual < 65535) m_dual++;
            if (m_dual_s < 3) m_dual_s++;
          end
        end
      end
      @(posedge clk); #1;
      chk($sformatf("rnd%0d_dual", c), int'(dual_cnt), m_dual);
      chk($sformatf("rnd%0d_ser", c), int'(serial_cnt), m_ser);
      chk($sformatf("rnd%0d_small_dual", c), int'(s_dual), m_dual_s);
      chk($sformatf("rnd%0d_small_ser", c), int'(s_serial), m_ser_s);
      if (c % 500 == 0)
        $display("rnd %0d: comb=%b dual=%0d ser=%0d sdual=%0d sser=%0d",
                 c, ec, dual_cnt, serial_cnt, s_dual, s_serial);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dual_issue_scheduler.md
Name: dual_issue_scheduler

Overview:
- Per-tick issue controller for the two-wide datapath (slot 0 / datapath 1, slot 1 / datapath 2).
- Each enabled tick it inspects the two queue-head instructions' register fields and issues both, one, or none.
- Dependent or conflicting pairs are serialized over two ticks; the block drives the queue freeze flags and the register-file write enables.
- Sits between the instruction queue/decoder and the dual register file + ALUs. Keeps saturating dual-issue and serialization counters for debug display.

Parameters:
- CNT_W, 16, width of the performance counters.
- REG_AW, 5, register address width; address 0 is hard-wired zero.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  synchronous, active-low reset.
- en  in  1  tick enable (one-cycle pulse from clock divider); all state updates qualified by it.
- valid0 / valid1  in  1  slot holds a real instruction (non-zero word).
- wr0 / wr1  in  1  slot instruction writes rd.
- rd0, rs1_0, rs2_0  in  REG_AW  slot 0 register fields.
- rd1, rs1_1, rs2_1  in  REG_AW  slot 1 register fields.
- use_rs2_1  in  1  slot 1 reads rs2 (0 for immediate forms).
- issue0 / issue1  out  1  datapath enable, combinational, valid only in en cycles.
- reg_write0 / reg_write1  out  1  register-file write strobes.
- freeze1 / freeze2  out  1  queue must hold slot 0 / slot 1 this tick.
- dependency_on_ins2  out  1  pair being serialized (registered state flag).
- dual_cnt / serial_cnt  out  CNT_W  saturating counts of dual issues / serializations.

Behaviour:
- Reset: clk edge with n_rst=0 gives state=ISSUE and counters=0. While n_rst=0, all combinational outputs are forced 0 and dependency_on_ins2=0.
- When en=0: issue*, reg_write* and freeze* are all 0; state and counters hold.
- Hazard (evaluated in ISSUE only): the pair has a hazard when valid0 & valid1 & wr0 & rd0!=0 & any of:
  - rd0==rs1_1
  - use_rs2_1 & rd0==rs2_1
  - wr1 & rd0==rd1 (WAW)
- State ISSUE, on en:
  - Both valid, no hazard: issue0=issue1=1, freezes 0, dual_cnt+1.
  - Both valid, hazard: issue0=1, issue1=0, freeze2=1, serial_cnt+1, next state SERIAL.
  - Only valid0: issue0=1. Only valid1: issue1=1. Neither valid: nothing asserted.
- State SERIAL (dependency_on_ins2=1), on en:
  - Slot 0 is retired and its inputs are ignored; freeze1=1 so the queue does not advance slot 0.
  - If valid1: issue1=1. Either way, next state ISSUE.
  - Slot 1 fields must be stable; the queue held them via freeze2.
- Write strobes: reg_writeN = issueN & wrN & (rdN!=0). Never write x0.
- Latency: issue decision is same-cycle combinational from inputs. A serialized pair completes in exactly two en ticks; slot 1 in tick 2 reads slot 0's committed result.
- Counters saturate at all-ones and never wrap.
- Reset asserted while in SERIAL: the held slot-1 instruction is dropped; the next tick starts fresh in ISSUE.
- Hazard on rd0==0 never triggers, whatever the rs values.

Test Plan:
- Reset, then en pulse with valid0=valid1=1, rd0=3, rs1_1=4, rs2_1=5, rd1=6, wr both 1 -> issue0=issue1=1, reg_write0=reg_write1=1, freezes 0, dual_cnt=1.
- RAW: rd0=3, rs1_1=3 -> tick 1: issue0=1, issue1=0, freeze2=1, serial_cnt=1, dependency_on_ins2=1. Tick 2: issue1=1, freeze1=1, issue0=0. Tick 3 back in ISSUE.
- Same fields as RAW but rd0=0 or wr0=0 -> dual issue, no serialization. Also rs2 match with use_rs2_1=0 -> dual issue.
- WAW: rd0=rd1=7, wr both 1 -> serialized over two ticks, and reg_write1 asserted only in tick 2.
- en held 0 for 10 cycles with hazard inputs -> all strobes 0, state/counters unchanged. Separately, n_rst=0 pulse while in SERIAL -> state ISSUE, counters 0, next tick dual-issues fresh pair.
- Preload/force dual_cnt=0xFFFE, then three no-hazard dual ticks -> reads 0xFFFF, no wrap.
